// File: rtl/dht11_start_ctrl_pkg.sv
// Shared DHT11 definitions: FSM states, error codes and timing defaults.
// The data receiver imports the same package.
package dht11_start_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START_LOW = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RESP_LOW  = 3'd3,
    ST_RESP_HIGH = 3'd4,
    ST_DONE      = 3'd5,
    ST_ERR       = 3'd6
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_NO_ACK   = 2'b01;
  localparam logic [1:0] ERR_BAD_LOW  = 2'b10;
  localparam logic [1:0] ERR_BAD_HIGH = 2'b11;

  localparam int DHT_CLK_FREQ_HZ    = 50_000_000;
  localparam int DHT_START_LOW_US   = 18000;
  localparam int DHT_ACK_WAIT_MAX_US = 100;
  localparam int DHT_RESP_US        = 80;
  localparam int DHT_RESP_TOL_US    = 20;
  localparam int US_W               = 15;

  function automatic logic in_window(input logic [US_W:0] v,
                                     input logic [US_W:0] lo,
                                     input logic [US_W:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// One-cycle pulse every microsecond; clr restarts the period so the first
// tick lands a full microsecond after a state change.
module dht11_us_tick #(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int DIV = (CLK_FREQ_HZ / 1_000_000 < 1) ? 1 : CLK_FREQ_HZ / 1_000_000;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/dht11_start_ctrl.sv
// DHT11 host start pulse and sensor response validation; hands off to the
// data receiver with a one-cycle confirm, or reports a one-cycle error.
import dht11_start_ctrl_pkg::*;

module dht11_start_ctrl #(
  parameter int CLK_FREQ_HZ     = DHT_CLK_FREQ_HZ,
  parameter int START_LOW_US    = DHT_START_LOW_US,
  parameter int ACK_WAIT_MAX_US = DHT_ACK_WAIT_MAX_US,
  parameter int RESP_US         = DHT_RESP_US,
  parameter int RESP_TOL_US     = DHT_RESP_TOL_US
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dht11_in,
  output logic       dht11_oe,
  output logic       busy,
  output logic       confirm_to_reciver,
  output logic       resp_err,
  output logic [1:0] err_code
);

  localparam logic [US_W:0] T_START = (US_W+1)'(START_LOW_US);
  localparam logic [US_W:0] T_ACK   = (US_W+1)'(ACK_WAIT_MAX_US);
  localparam logic [US_W:0] T_LO    = (US_W+1)'(RESP_US - RESP_TOL_US);
  localparam logic [US_W:0] T_HI    = (US_W+1)'(RESP_US + RESP_TOL_US);

  state_e            state_q, state_d;
  logic [US_W-1:0]   us_q, us_d;
  logic [US_W:0]     us_eff;
  logic [1:0]        err_q, err_d;
  logic              sync1_q, sync2_q;
  logic              oe_q, busy_q, conf_q, rerr_q;
  logic              tick, clr;

  // Idle bus is pulled high, so the synchronizer resets high to avoid a
  // phantom low right after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= dht11_in;
      sync2_q <= sync1_q;
    end
  end

  assign clr = (state_d != state_q) || (state_q == ST_IDLE);

  dht11_us_tick #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  // Count including a tick landing this cycle, so edge decisions see whole us.
  assign us_eff = {1'b0, us_q} + {{US_W{1'b0}}, tick};

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_START_LOW;
        err_d   = ERR_NONE;
      end
      ST_START_LOW: if (us_eff >= T_START) state_d = ST_RELEASE;
      ST_RELEASE: begin
        if (!sync2_q) state_d = ST_RESP_LOW;
        else if (us_eff >= T_ACK) begin
          state_d = ST_ERR;
          err_d   = ERR_NO_ACK;
        end
      end
      ST_RESP_LOW: begin
        if (sync2_q) begin
          if (in_window(us_eff, T_LO, T_HI)) state_d = ST_RESP_HIGH;
          else begin
            state_d = ST_ERR;
            err_d   = ERR_BAD_LOW;
          end
        end else if (us_eff > T_HI) begin
          state_d = ST_ERR;
          err_d   = ERR_BAD_LOW;
        end
      end
      ST_RESP_HIGH: begin
        if (!sync2_q) begin
          if (in_window(us_eff, T_LO, T_HI)) state_d = ST_DONE;
          else begin
            state_d = ST_ERR;
            err_d   = ERR_BAD_HIGH;
          end
        end else if (us_eff > T_HI) begin
          state_d = ST_ERR;
          err_d   = ERR_BAD_HIGH;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    us_d = us_q;
    if (clr) us_d = '0;
    else if (tick && us_q != '1) us_d = us_q + 1'b1;
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      us_q    <= '0;
      err_q   <= ERR_NONE;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      conf_q  <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      us_q    <= us_d;
      err_q   <= err_d;
      oe_q    <= (state_d == ST_START_LOW);
      busy_q  <= (state_d inside {ST_START_LOW, ST_RELEASE, ST_RESP_LOW, ST_RESP_HIGH});
      conf_q  <= (state_d == ST_DONE);
      rerr_q  <= (state_d == ST_ERR);
    end
  end

  assign dht11_oe           = oe_q;
  assign busy               = busy_q;
  assign confirm_to_reciver = conf_q;
  assign resp_err           = rerr_q;
  assign err_code           = err_q;

endmodule
